// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - frame-buffer swap controller (stats counters enabled by FB_SWAP_STATS_EN)
module fb_swap_ctrl #(
   parameter  int NUM_BUFS        = 2,
   parameter  int MAX_OUTSTANDING = 8,
   localparam int BUF_BITS        = $clog2(NUM_BUFS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                prod_awfire,
   input  logic                prod_bfire,
   input  logic                prod_last,
   input  logic                vsync,
   output logic [BUF_BITS-1:0] prod_buf,
   output logic [BUF_BITS-1:0] disp_buf,
   output logic                prod_stall,
   output logic                prod_restart,
   output logic                aw_block,
   output logic                disp_enable,
   output logic                err_underflow,
   output logic [15:0]         drop_cnt,
   output logic [15:0]         repeat_cnt
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [0:0]          ST_INIT  = 1'b0;
   localparam logic [0:0]          ST_RUN   = 1'b1;
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [BUF_BITS-1:0] DISP_RST = BUF_BITS'(NUM_BUFS - 1);

   logic [0:0]          state_q, state_d;
   logic [BUF_BITS-1:0] prod_buf_q, prod_buf_d;
   logic [BUF_BITS-1:0] disp_buf_q, disp_buf_d;
   logic [BUF_BITS-1:0] pend_buf_q, pend_buf_d;
   logic                pend_valid_q, pend_valid_d;
   logic [CNT_W-1:0]    outstanding_q, outstanding_d;
   logic                last_seen_q, last_seen_d;
   logic                vsync_q, vsync_d;
   logic                prod_stall_q, prod_stall_d;
   logic                prod_restart_q, prod_restart_d;
   logic                disp_enable_q, disp_enable_d;
   logic                err_underflow_q, err_underflow_d;
   logic [2:0]          ign_q, ign_d;
   logic [BUF_BITS-1:0] free_buf;

   logic vfall;
   logic done;
   logic b_ignore;

   assign vfall    = vsync_q & ~vsync;
   assign done     = last_seen_q & (outstanding_q == '0);
   // B responses still in flight from before a reset must not raise the error flag
   assign b_ignore = (ign_q != 3'd0);

   // In-flight write accounting, underflow detection and post-reset B-ignore window
   always_comb begin
      outstanding_d   = outstanding_q;
      err_underflow_d = err_underflow_q;
      ign_d           = (ign_q != 3'd0) ? ign_q - 3'd1 : ign_q;
      vsync_d         = vsync;
      if (prod_awfire && !prod_bfire) begin
         if (outstanding_q != CNT_MAX) outstanding_d = outstanding_q + CNT_ONE;
      end else if (prod_bfire && !prod_awfire) begin
         if (outstanding_q != '0)  outstanding_d   = outstanding_q - CNT_ONE;
         else if (!b_ignore)       err_underflow_d = 1'b1;
      end
   end

   // Lowest-numbered buffer that is neither shown nor being written
   always_comb begin
      free_buf = '0;
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         if ((BUF_BITS'(i) != disp_buf_q) && (BUF_BITS'(i) != prod_buf_q)) free_buf = BUF_BITS'(i);
      end
   end

   // Frame completion tracking and buffer rotation
   always_comb begin
      state_d        = state_q;
      prod_buf_d     = prod_buf_q;
      disp_buf_d     = disp_buf_q;
      pend_buf_d     = pend_buf_q;
      pend_valid_d   = pend_valid_q;
      prod_stall_d   = prod_stall_q;
      prod_restart_d = 1'b0;
      disp_enable_d  = disp_enable_q;
      last_seen_d    = last_seen_q;
      if (done)      last_seen_d = 1'b0;
      if (prod_last) last_seen_d = 1'b1;

      if (state_q == ST_INIT) begin
         // first frame goes straight to the display, no vsync alignment needed
         if (done) begin
            disp_buf_d     = prod_buf_q;
            prod_buf_d     = disp_buf_q;
            prod_restart_d = 1'b1;
            disp_enable_d  = 1'b1;
            state_d        = ST_RUN;
         end
      end else if (NUM_BUFS == 2) begin
         // double buffering: producer waits for the display to release its buffer
         if (vfall && pend_valid_q) begin
            disp_buf_d     = prod_buf_q;
            prod_buf_d     = disp_buf_q;
            pend_valid_d   = 1'b0;
            prod_stall_d   = 1'b0;
            prod_restart_d = 1'b1;
         end
         if (done) begin
            pend_valid_d = 1'b1;
            prod_stall_d = 1'b1;
         end
      end else begin
         // triple/quad buffering: producer never waits, stale pending frames are dropped
         if (vfall && pend_valid_q && done) begin
            disp_buf_d     = pend_buf_q;
            pend_buf_d     = prod_buf_q;
            prod_buf_d     = disp_buf_q;
            prod_restart_d = 1'b1;
         end else if (done) begin
            pend_buf_d     = prod_buf_q;
            pend_valid_d   = 1'b1;
            prod_restart_d = 1'b1;
            prod_buf_d     = pend_valid_q ? pend_buf_q : free_buf;
         end else if (vfall && pend_valid_q) begin
            disp_buf_d   = pend_buf_q;
            pend_valid_d = 1'b0;
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_INIT;
         prod_buf_q      <= '0;
         disp_buf_q      <= DISP_RST;
         pend_buf_q      <= '0;
         pend_valid_q    <= 1'b0;
         outstanding_q   <= '0;
         last_seen_q     <= 1'b0;
         vsync_q         <= 1'b1;
         prod_stall_q    <= 1'b0;
         prod_restart_q  <= 1'b0;
         disp_enable_q   <= 1'b0;
         err_underflow_q <= 1'b0;
         ign_q           <= 3'd4;
      end else begin
         state_q         <= state_d;
         prod_buf_q      <= prod_buf_d;
         disp_buf_q      <= disp_buf_d;
         pend_buf_q      <= pend_buf_d;
         pend_valid_q    <= pend_valid_d;
         outstanding_q   <= outstanding_d;
         last_seen_q     <= last_seen_d;
         vsync_q         <= vsync_d;
         prod_stall_q    <= prod_stall_d;
         prod_restart_q  <= prod_restart_d;
         disp_enable_q   <= disp_enable_d;
         err_underflow_q <= err_underflow_d;
         ign_q           <= ign_d;
      end
   end

`ifdef FB_SWAP_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [15:0] repeat_cnt_q, repeat_cnt_d;
   logic        drop_inc;
   logic        repeat_inc;

   assign repeat_inc = (state_q == ST_RUN) & vfall & ~pend_valid_q;
   assign drop_inc   = (NUM_BUFS > 2) & (state_q == ST_RUN) & done & pend_valid_q & ~vfall;

   // Saturating statistics counters
   always_comb begin
      drop_cnt_d   = drop_cnt_q;
      repeat_cnt_d = repeat_cnt_q;
      if (drop_inc && (drop_cnt_q != 16'hFFFF))     drop_cnt_d   = drop_cnt_q + 16'd1;
      if (repeat_inc && (repeat_cnt_q != 16'hFFFF)) repeat_cnt_d = repeat_cnt_q + 16'd1;
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q   <= 16'd0;
         repeat_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q   <= drop_cnt_d;
         repeat_cnt_q <= repeat_cnt_d;
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign repeat_cnt = repeat_cnt_q;
`else
   assign drop_cnt   = 16'd0;
   assign repeat_cnt = 16'd0;
`endif

   assign prod_buf      = prod_buf_q;
   assign disp_buf      = disp_buf_q;
   assign prod_stall    = prod_stall_q;
   assign prod_restart  = prod_restart_q;
   assign aw_block      = (outstanding_q == CNT_MAX);
   assign disp_enable   = disp_enable_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb/tb_fb_swap_ctrl.sv - directed bench for fb_swap_ctrl in double- and triple-buffer builds
module tb_fb_swap_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic prod_awfire = 1'b0;
   logic prod_bfire = 1'b0;
   logic prod_last = 1'b0;
   logic vsync = 1'b0;

   logic [0:0]  p2_prod_buf, p2_disp_buf;
   logic        p2_stall, p2_restart, p2_aw_block, p2_enable, p2_err;
   logic [15:0] p2_drop, p2_repeat;
   logic [1:0]  p3_prod_buf, p3_disp_buf;
   logic        p3_stall, p3_restart, p3_aw_block, p3_enable, p3_err;
   logic [15:0] p3_drop, p3_repeat;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef FB_SWAP_STATS_EN
   localparam logic [15:0] ST1 = 16'd1;
`else
   localparam logic [15:0] ST1 = 16'd0;
`endif

   always #5 clk = ~clk;

   fb_swap_ctrl #(.NUM_BUFS(2), .MAX_OUTSTANDING(8)) dut2 (
      .clk(clk), .reset(reset), .prod_awfire(prod_awfire), .prod_bfire(prod_bfire),
      .prod_last(prod_last), .vsync(vsync), .prod_buf(p2_prod_buf), .disp_buf(p2_disp_buf),
      .prod_stall(p2_stall), .prod_restart(p2_restart), .aw_block(p2_aw_block),
      .disp_enable(p2_enable), .err_underflow(p2_err), .drop_cnt(p2_drop), .repeat_cnt(p2_repeat)
   );

   fb_swap_ctrl #(.NUM_BUFS(3), .MAX_OUTSTANDING(8)) dut3 (
      .clk(clk), .reset(reset), .prod_awfire(prod_awfire), .prod_bfire(prod_bfire),
      .prod_last(prod_last), .vsync(vsync), .prod_buf(p3_prod_buf), .disp_buf(p3_disp_buf),
      .prod_stall(p3_stall), .prod_restart(p3_restart), .aw_block(p3_aw_block),
      .disp_enable(p3_enable), .err_underflow(p3_err), .drop_cnt(p3_drop), .repeat_cnt(p3_repeat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; prod_awfire = 1'b0; prod_bfire = 1'b0; prod_last = 1'b0; vsync = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_frame(input int n);
      prod_awfire = 1'b1;
      repeat (n) step();
      prod_awfire = 1'b0;
      prod_last = 1'b1;
      step();
      prod_last = 1'b0;
      prod_bfire = 1'b1;
      repeat (n) step();
      prod_bfire = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_cmp++; if (p2_prod_buf !== 1'd0) begin n_bad++; $display("FAIL rst2_prod_buf got %0d exp 0", p2_prod_buf); end
      n_cmp++; if (p2_disp_buf !== 1'd1) begin n_bad++; $display("FAIL rst2_disp_buf got %0d exp 1", p2_disp_buf); end
      n_cmp++; if ({p2_stall, p2_restart, p2_aw_block, p2_enable, p2_err} !== 5'b0) begin n_bad++;
         $display("FAIL rst2_flags got %b exp 00000", {p2_stall, p2_restart, p2_aw_block, p2_enable, p2_err}); end
      n_cmp++; if ({p2_drop, p2_repeat} !== 32'd0) begin n_bad++; $display("FAIL rst2_counters got %h exp 0", {p2_drop, p2_repeat}); end
      n_cmp++; if (p3_prod_buf !== 2'd0) begin n_bad++; $display("FAIL rst3_prod_buf got %0d exp 0", p3_prod_buf); end
      n_cmp++; if (p3_disp_buf !== 2'd2) begin n_bad++; $display("FAIL rst3_disp_buf got %0d exp 2", p3_disp_buf); end
      n_cmp++; if ({p3_stall, p3_restart, p3_aw_block, p3_enable, p3_err} !== 5'b0) begin n_bad++;
         $display("FAIL rst3_flags got %b exp 00000", {p3_stall, p3_restart, p3_aw_block, p3_enable, p3_err}); end
      n_cmp++; if ({p3_drop, p3_repeat} !== 32'd0) begin n_bad++; $display("FAIL rst3_counters got %h exp 0", {p3_drop, p3_repeat}); end
   endtask

   task automatic test_first_frame();
      do_reset();
      run_frame(3);
      n_cmp++; if (p2_enable !== 1'b0) begin n_bad++; $display("FAIL first_enable_early got %b exp 0", p2_enable); end
      step();
      n_cmp++; if (p2_enable !== 1'b1) begin n_bad++; $display("FAIL first_enable got %b exp 1", p2_enable); end
      n_cmp++; if (p2_prod_buf !== 1'd1) begin n_bad++; $display("FAIL first_prod_buf got %0d exp 1", p2_prod_buf); end
      n_cmp++; if (p2_disp_buf !== 1'd0) begin n_bad++; $display("FAIL first_disp_buf got %0d exp 0", p2_disp_buf); end
      n_cmp++; if (p2_restart !== 1'b1) begin n_bad++; $display("FAIL first_restart got %b exp 1", p2_restart); end
      n_cmp++; if (p3_prod_buf !== 2'd2 || p3_disp_buf !== 2'd0) begin n_bad++;
         $display("FAIL first3_bufs got prod=%0d disp=%0d exp prod=2 disp=0", p3_prod_buf, p3_disp_buf); end
      step();
      n_cmp++; if (p2_restart !== 1'b0) begin n_bad++; $display("FAIL first_restart_len got %b exp 0", p2_restart); end
      n_cmp++; if (p2_err !== 1'b0) begin n_bad++; $display("FAIL first_err got %b exp 0", p2_err); end
   endtask

   task automatic test_two_buf_swap();
      int stall_cycles;
      run_frame(2);
      step();
      n_cmp++; if (p2_stall !== 1'b1) begin n_bad++; $display("FAIL swap2_stall got %b exp 1", p2_stall); end
      n_cmp++; if (p2_prod_buf !== 1'd1 || p2_restart !== 1'b0) begin n_bad++;
         $display("FAIL swap2_no_early_swap got prod=%0d restart=%b exp prod=1 restart=0", p2_prod_buf, p2_restart); end
      stall_cycles = (p2_stall === 1'b1) ? 1 : 0;
      vsync = 1'b1;
      repeat (49) begin
         step();
         if (p2_stall === 1'b1) stall_cycles++;
      end
      vsync = 1'b0;
      step();
      n_cmp++; if (stall_cycles != 50) begin n_bad++; $display("FAIL swap2_stall_len got %0d exp 50", stall_cycles); end
      n_cmp++; if (p2_stall !== 1'b0 || p2_restart !== 1'b1) begin n_bad++;
         $display("FAIL swap2_release got stall=%b restart=%b exp stall=0 restart=1", p2_stall, p2_restart); end
      n_cmp++; if (p2_prod_buf !== 1'd0 || p2_disp_buf !== 1'd1) begin n_bad++;
         $display("FAIL swap2_bufs got prod=%0d disp=%0d exp prod=0 disp=1", p2_prod_buf, p2_disp_buf); end
      n_cmp++; if (p2_repeat !== 16'd0) begin n_bad++; $display("FAIL swap2_repeat0 got %0d exp 0", p2_repeat); end
      step();
      n_cmp++; if (p2_restart !== 1'b0) begin n_bad++; $display("FAIL swap2_restart_len got %b exp 0", p2_restart); end
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      n_cmp++; if (p2_repeat !== ST1) begin n_bad++; $display("FAIL swap2_repeat got %0d exp %0d", p2_repeat, ST1); end
      n_cmp++; if (p2_disp_buf !== 1'd1) begin n_bad++; $display("FAIL swap2_repeat_disp got %0d exp 1", p2_disp_buf); end
   endtask

   task automatic test_three_buf();
      do_reset();
      run_frame(1);
      step();
      step();
      run_frame(1);
      step();
      n_cmp++; if (p3_prod_buf !== 2'd1 || p3_restart !== 1'b1) begin n_bad++;
         $display("FAIL tri_first_done got prod=%0d restart=%b exp prod=1 restart=1", p3_prod_buf, p3_restart); end
      run_frame(1);
      step();
      n_cmp++; if (p3_prod_buf !== 2'd2) begin n_bad++; $display("FAIL tri_drop_prod got %0d exp 2", p3_prod_buf); end
      n_cmp++; if (p3_drop !== ST1) begin n_bad++; $display("FAIL tri_drop_cnt got %0d exp %0d", p3_drop, ST1); end
      n_cmp++; if (p3_stall !== 1'b0) begin n_bad++; $display("FAIL tri_stall got %b exp 0", p3_stall); end
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      n_cmp++; if (p3_disp_buf !== 2'd1 || p3_prod_buf !== 2'd2) begin n_bad++;
         $display("FAIL tri_show_newest got disp=%0d prod=%0d exp disp=1 prod=2", p3_disp_buf, p3_prod_buf); end
      run_frame(1);
      step();
      n_cmp++; if (p3_prod_buf !== 2'd0) begin n_bad++; $display("FAIL tri_free_pick got %0d exp 0", p3_prod_buf); end
      vsync = 1'b1;
      run_frame(1);
      vsync = 1'b0;
      step();
      n_cmp++; if (p3_disp_buf !== 2'd2 || p3_prod_buf !== 2'd1) begin n_bad++;
         $display("FAIL tri_vfall_done got disp=%0d prod=%0d exp disp=2 prod=1", p3_disp_buf, p3_prod_buf); end
      n_cmp++; if (p3_drop !== ST1 || p3_repeat !== 16'd0) begin n_bad++;
         $display("FAIL tri_vfall_done_cnt got drop=%0d repeat=%0d exp drop=%0d repeat=0", p3_drop, p3_repeat, ST1); end
      n_cmp++; if (p3_stall !== 1'b0 || p3_restart !== 1'b1) begin n_bad++;
         $display("FAIL tri_vfall_done_flags got stall=%b restart=%b exp 0 1", p3_stall, p3_restart); end
   endtask

   task automatic test_aw_block();
      do_reset();
      prod_awfire = 1'b1;
      repeat (7) step();
      n_cmp++; if (p2_aw_block !== 1'b0) begin n_bad++; $display("FAIL awblk_at7 got %b exp 0", p2_aw_block); end
      step();
      n_cmp++; if (p2_aw_block !== 1'b1) begin n_bad++; $display("FAIL awblk_at8 got %b exp 1", p2_aw_block); end
      prod_awfire = 1'b0;
      prod_bfire = 1'b1;
      step();
      prod_bfire = 1'b0;
      n_cmp++; if (p2_aw_block !== 1'b0) begin n_bad++; $display("FAIL awblk_release got %b exp 0", p2_aw_block); end
   endtask

   task automatic test_simultaneous_and_underflow();
      prod_bfire = 1'b1;
      repeat (2) step();
      prod_awfire = 1'b1;
      step();
      prod_bfire = 1'b0;
      repeat (2) step();
      n_cmp++; if (p2_aw_block !== 1'b0) begin n_bad++; $display("FAIL both_count7 got %b exp 0", p2_aw_block); end
      step();
      prod_awfire = 1'b0;
      n_cmp++; if (p2_aw_block !== 1'b1) begin n_bad++; $display("FAIL both_count8 got %b exp 1", p2_aw_block); end
      prod_bfire = 1'b1;
      repeat (8) step();
      n_cmp++; if (p2_err !== 1'b0) begin n_bad++; $display("FAIL under_early got %b exp 0", p2_err); end
      step();
      prod_bfire = 1'b0;
      n_cmp++; if (p2_err !== 1'b1 || p3_err !== 1'b1) begin n_bad++;
         $display("FAIL under_flag got %b/%b exp 1/1", p2_err, p3_err); end
      prod_awfire = 1'b1;
      repeat (7) step();
      n_cmp++; if (p2_aw_block !== 1'b0) begin n_bad++; $display("FAIL under_count_7 got %b exp 0", p2_aw_block); end
      step();
      prod_awfire = 1'b0;
      n_cmp++; if (p2_aw_block !== 1'b1) begin n_bad++; $display("FAIL under_count_8 got %b exp 1", p2_aw_block); end
   endtask

   task automatic test_post_reset_ignore();
      do_reset();
      prod_bfire = 1'b1;
      repeat (4) step();
      n_cmp++; if (p2_err !== 1'b0) begin n_bad++; $display("FAIL ignore_window got %b exp 0", p2_err); end
      step();
      prod_bfire = 1'b0;
      n_cmp++; if (p2_err !== 1'b1) begin n_bad++; $display("FAIL ignore_expired got %b exp 1", p2_err); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      run_frame(1);
      step();
      prod_bfire = 1'b1;
      step();
      prod_bfire = 1'b0;
      n_cmp++; if (p2_err !== 1'b1 || p2_enable !== 1'b1) begin n_bad++;
         $display("FAIL mid_pre got err=%b en=%b exp 1 1", p2_err, p2_enable); end
      prod_awfire = 1'b1;
      repeat (4) step();
      prod_awfire = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (p2_prod_buf !== 1'd0 || p2_disp_buf !== 1'd1) begin n_bad++;
         $display("FAIL mid_bufs got prod=%0d disp=%0d exp 0 1", p2_prod_buf, p2_disp_buf); end
      n_cmp++; if ({p2_stall, p2_restart, p2_aw_block, p2_enable, p2_err} !== 5'b0) begin n_bad++;
         $display("FAIL mid_flags got %b exp 00000", {p2_stall, p2_restart, p2_aw_block, p2_enable, p2_err}); end
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      prod_bfire = 1'b1;
      step();
      prod_bfire = 1'b0;
      n_cmp++; if (p2_repeat !== 16'd0 || p2_enable !== 1'b0 || p2_err !== 1'b0) begin n_bad++;
         $display("FAIL mid_init got repeat=%0d en=%b err=%b exp 0 0 0", p2_repeat, p2_enable, p2_err); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_two_buf_swap();
      test_three_buf();
      test_aw_block();
      test_simultaneous_and_underflow();
      test_post_reset_ignore();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
